// File: rtl/infra_align_bw_sched_pkg.sv
// Shared types and constants for the align_bw_pseudo request scheduler.
// Holds the scheduler state encoding and the zero-fill sweep length helper.
package infra_align_bw_sched_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // One write per (bank,row) pair during the post-reset zero fill.
  function automatic int sweep_len(input int nbnk, input int nrow);
    return nbnk * nrow;
  endfunction

  localparam int DEF_SWEEP_LEN = sweep_len(8, 1024);

endpackage

// File: rtl/infra_rr_arb.sv
// Round-robin arbiter: search starts at the pointer and ascends with wrap.
// On a grant the pointer moves to winner+1; otherwise it holds.
module infra_rr_arb #(
  parameter int NUMREQ = 4,
  parameter int BITREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUMREQ-1:0] i_req,
  output logic [NUMREQ-1:0] o_gnt,
  output logic [BITREQ-1:0] o_win,
  output logic              o_any,
  output logic [BITREQ-1:0] o_ptr
);

  localparam logic [BITREQ:0]   NREQ_W = (BITREQ+1)'(NUMREQ);
  localparam logic [BITREQ-1:0] LAST_W = BITREQ'(NUMREQ - 1);

  logic [BITREQ-1:0] r_ptr;
  logic [BITREQ:0]   w_sum;
  logic [BITREQ-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < NUMREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (BITREQ+1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      w_idx = w_sum[BITREQ-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_win        = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_win == LAST_W) ? '0 : o_win + BITREQ'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/infra_align_bw_sched.sv
// Scheduler in front of the align_bw_pseudo core: optional zero-fill sweep,
// independent round-robin write/read arbitration and read-response steering.
module infra_align_bw_sched
  import infra_align_bw_sched_pkg::*;
#(
  parameter int NUMREQ   = 4,
  parameter int BITREQ   = 2,
  parameter int WIDTH    = 32,
  parameter int NUMVROW  = 1024,
  parameter int BITVROW  = 10,
  parameter int NUMVBNK  = 8,
  parameter int BITVBNK  = 3,
  parameter int RD_DELAY = 3,
  parameter int RSTINIT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMREQ-1:0]          req_write,
  input  logic [NUMREQ*BITVBNK-1:0]  req_wr_bnk,
  input  logic [NUMREQ*BITVROW-1:0]  req_wr_adr,
  input  logic [NUMREQ*WIDTH-1:0]    req_bw,
  input  logic [NUMREQ*WIDTH-1:0]    req_din,
  output logic [NUMREQ-1:0]          req_wr_ready,
  input  logic [NUMREQ-1:0]          req_read,
  input  logic [NUMREQ*BITVBNK-1:0]  req_rd_bnk,
  input  logic [NUMREQ*BITVROW-1:0]  req_rd_adr,
  output logic [NUMREQ-1:0]          req_rd_ready,
  output logic [NUMREQ-1:0]          rsp_vld,
  output logic [WIDTH-1:0]           rsp_dout,
  output logic                       rsp_serr,
  output logic                       rsp_derr,
  output logic                       write,
  output logic [BITVBNK-1:0]         wr_bnk,
  output logic [BITVROW-1:0]         wr_adr,
  output logic [WIDTH-1:0]           bw,
  output logic [WIDTH-1:0]           din,
  output logic                       read,
  output logic [BITVBNK-1:0]         rd_bnk,
  output logic [BITVROW-1:0]         rd_adr,
  input  logic [WIDTH-1:0]           rd_dout,
  input  logic                       rd_serr,
  input  logic                       rd_derr,
  output logic                       init_done
);

  sched_state_t r_state, w_state_next;
  logic [BITVROW-1:0] r_row;
  logic [BITVBNK-1:0] r_bnk;
  logic               r_sweep_end;
  logic               w_run, w_last_pos;

  logic [BITVBNK-1:0] w_wr_bnk_a [NUMREQ];
  logic [BITVROW-1:0] w_wr_adr_a [NUMREQ];
  logic [WIDTH-1:0]   w_bw_a     [NUMREQ];
  logic [WIDTH-1:0]   w_din_a    [NUMREQ];
  logic [BITVBNK-1:0] w_rd_bnk_a [NUMREQ];
  logic [BITVROW-1:0] w_rd_adr_a [NUMREQ];

  for (genvar gi = 0; gi < NUMREQ; gi++) begin : g_unpack
    assign w_wr_bnk_a[gi] = req_wr_bnk[gi*BITVBNK +: BITVBNK];
    assign w_wr_adr_a[gi] = req_wr_adr[gi*BITVROW +: BITVROW];
    assign w_bw_a[gi]     = req_bw[gi*WIDTH +: WIDTH];
    assign w_din_a[gi]    = req_din[gi*WIDTH +: WIDTH];
    assign w_rd_bnk_a[gi] = req_rd_bnk[gi*BITVBNK +: BITVBNK];
    assign w_rd_adr_a[gi] = req_rd_adr[gi*BITVROW +: BITVROW];
  end

  assign w_run      = (r_state == RUN);
  assign init_done  = w_run;
  assign w_last_pos = (r_bnk == BITVBNK'(NUMVBNK - 1)) && (r_row == BITVROW'(NUMVROW - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if (r_sweep_end) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= (RSTINIT != 0) ? INIT : RUN;
    else     r_state <= w_state_next;
  end

  // Row is the inner counter so NUMVROW need not be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_bnk       <= '0;
      r_sweep_end <= 1'b0;
    end else if (!w_run && !r_sweep_end) begin
      if (w_last_pos) begin
        r_sweep_end <= 1'b1;
      end else if (r_row == BITVROW'(NUMVROW - 1)) begin
        r_row <= '0;
        r_bnk <= r_bnk + BITVBNK'(1);
      end else begin
        r_row <= r_row + BITVROW'(1);
      end
    end
  end

  logic [NUMREQ-1:0] w_wr_gnt, w_rd_gnt;
  logic [BITREQ-1:0] w_wr_win, w_rd_win;
  logic              w_wr_any, w_rd_any;
  logic [BITREQ-1:0] w_unused_wr_ptr, w_unused_rd_ptr;

  infra_rr_arb #(.NUMREQ(NUMREQ), .BITREQ(BITREQ)) u_wr_arb (
    .clk(clk), .rst(rst), .i_req(req_write & {NUMREQ{w_run}}),
    .o_gnt(w_wr_gnt), .o_win(w_wr_win), .o_any(w_wr_any), .o_ptr(w_unused_wr_ptr)
  );

  infra_rr_arb #(.NUMREQ(NUMREQ), .BITREQ(BITREQ)) u_rd_arb (
    .clk(clk), .rst(rst), .i_req(req_read & {NUMREQ{w_run}}),
    .o_gnt(w_rd_gnt), .o_win(w_rd_win), .o_any(w_rd_any), .o_ptr(w_unused_rd_ptr)
  );

  assign req_wr_ready = w_wr_gnt;
  assign req_rd_ready = w_rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      write  <= 1'b0;
      wr_bnk <= '0;
      wr_adr <= '0;
      bw     <= '0;
      din    <= '0;
      read   <= 1'b0;
      rd_bnk <= '0;
      rd_adr <= '0;
    end else if (!w_run) begin
      write  <= !r_sweep_end;
      wr_bnk <= r_bnk;
      wr_adr <= r_row;
      bw     <= '1;
      din    <= '0;
      read   <= 1'b0;
    end else begin
      write <= w_wr_any;
      read  <= w_rd_any;
      if (w_wr_any) begin
        wr_bnk <= w_wr_bnk_a[w_wr_win];
        wr_adr <= w_wr_adr_a[w_wr_win];
        bw     <= w_bw_a[w_wr_win];
        din    <= w_din_a[w_wr_win];
      end
      if (w_rd_any) begin
        rd_bnk <= w_rd_bnk_a[w_rd_win];
        rd_adr <= w_rd_adr_a[w_rd_win];
      end
    end
  end

  // Stage 0 lines up with the core read; stage RD_DELAY with rd_dout.
  logic [RD_DELAY:0] r_tag_vld;
  logic [BITREQ-1:0] r_tag [RD_DELAY+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= RD_DELAY; s++) r_tag[s] <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[RD_DELAY-1:0], w_rd_any};
      r_tag[0]  <= w_rd_win;
      for (int s = 1; s <= RD_DELAY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (r_tag_vld[RD_DELAY]) rsp_vld[r_tag[RD_DELAY]] = 1'b1;
  end

  assign rsp_dout = rd_dout;
  assign rsp_serr = rd_serr;
  assign rsp_derr = rd_derr;

endmodule

// File: tb/tb_infra_align_bw_sched.sv
// Bench for infra_align_bw_sched: zero-fill sweep, round-robin grant tables,
// scoreboarded core commands and steered read responses, reset while reads are in flight.
module tb_infra_align_bw_sched;
  import infra_align_bw_sched_pkg::*;

  localparam int NR = 4, BR = 2, W = 32, NV = 4, BV = 10, NB = 2, BB = 3, RDD = 3;
  localparam int SWEEP = sweep_len(NB, NV);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_write = '0, req_read = '0;
  logic [BB-1:0] p_wr_bnk [NR], p_rd_bnk [NR];
  logic [BV-1:0] p_wr_adr [NR], p_rd_adr [NR];
  logic [W-1:0]  p_bw [NR], p_din [NR];
  logic [NR*BB-1:0] req_wr_bnk, req_rd_bnk;
  logic [NR*BV-1:0] req_wr_adr, req_rd_adr;
  logic [NR*W-1:0]  req_bw, req_din;
  logic [NR-1:0] req_wr_ready, req_rd_ready, rsp_vld;
  logic [W-1:0]  rsp_dout, bw, din;
  logic rsp_serr, rsp_derr, write, read, init_done;
  logic [BB-1:0] wr_bnk, rd_bnk;
  logic [BV-1:0] wr_adr, rd_adr;
  logic [W-1:0]  rd_dout = '0;
  logic rd_serr = 1'b0, rd_derr = 1'b0;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_wr_bnk[gi*BB +: BB] = p_wr_bnk[gi];
    assign req_wr_adr[gi*BV +: BV] = p_wr_adr[gi];
    assign req_bw[gi*W +: W]       = p_bw[gi];
    assign req_din[gi*W +: W]      = p_din[gi];
    assign req_rd_bnk[gi*BB +: BB] = p_rd_bnk[gi];
    assign req_rd_adr[gi*BV +: BV] = p_rd_adr[gi];
  end

  infra_align_bw_sched #(
    .NUMREQ(NR), .BITREQ(BR), .WIDTH(W), .NUMVROW(NV), .BITVROW(BV),
    .NUMVBNK(NB), .BITVBNK(BB), .RD_DELAY(RDD), .RSTINIT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_write(req_write), .req_wr_bnk(req_wr_bnk), .req_wr_adr(req_wr_adr),
    .req_bw(req_bw), .req_din(req_din), .req_wr_ready(req_wr_ready),
    .req_read(req_read), .req_rd_bnk(req_rd_bnk), .req_rd_adr(req_rd_adr),
    .req_rd_ready(req_rd_ready),
    .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
    .write(write), .wr_bnk(wr_bnk), .wr_adr(wr_adr), .bw(bw), .din(din),
    .read(read), .rd_bnk(rd_bnk), .rd_adr(rd_adr),
    .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rd_dout = $urandom;
      rd_serr = 1'($urandom_range(0, 1));
      rd_derr = 1'($urandom_range(0, 1));
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic [BB-1:0] bnk;
    logic [BV-1:0] adr;
    logic [W-1:0]  bw;
    logic [W-1:0]  din;
  } cmd_t;

  typedef struct {
    int due;
    int tag;
  } rsp_t;

  cmd_t wr_q[$], rd_q[$];
  rsp_t rsp_q[$];
  bit   mon_en = 1'b0;
  cmd_t wc, rc;
  rsp_t rs;
  logic [NR-1:0] exp_vld;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        wc = wr_q.pop_front();
        chk("core_write", 64'(write), 64'd1);
        chk("wr_bnk", 64'(wr_bnk), 64'(wc.bnk));
        chk("wr_adr", 64'(wr_adr), 64'(wc.adr));
        chk("bw", 64'(bw), 64'(wc.bw));
        chk("din", 64'(din), 64'(wc.din));
      end else begin
        chk("core_write_idle", 64'(write), 64'd0);
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        rc = rd_q.pop_front();
        chk("core_read", 64'(read), 64'd1);
        chk("rd_bnk", 64'(rd_bnk), 64'(rc.bnk));
        chk("rd_adr", 64'(rd_adr), 64'(rc.adr));
      end else begin
        chk("core_read_idle", 64'(read), 64'd0);
      end
      exp_vld = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        rs = rsp_q.pop_front();
        exp_vld[rs.tag] = 1'b1;
      end
      chk("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
      if (exp_vld != '0) begin
        chk("rsp_dout", 64'(rsp_dout), 64'(rd_dout));
        chk("rsp_serr", 64'(rsp_serr), 64'(rd_serr));
        chk("rsp_derr", 64'(rsp_derr), 64'(rd_derr));
      end
    end
  end

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < NR; i++) begin
      p_wr_bnk[i] = BB'($urandom_range(0, 7));
      p_wr_adr[i] = BV'($urandom_range(0, 1023));
      p_bw[i]     = $urandom;
      p_din[i]    = $urandom;
      p_rd_bnk[i] = BB'($urandom_range(0, 7));
      p_rd_adr[i] = BV'($urandom_range(0, 1023));
    end
  endtask

  // One request cycle: drive after the edge, check grants mid-cycle, queue expectations.
  task automatic apply(input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                       input logic [NR-1:0] erd, input logic [NR-1:0] ewr, input bit rnd);
    int w;
    @(posedge clk);
    #1;
    if (rnd) rand_payload();
    req_read  = rd;
    req_write = wr;
    @(negedge clk);
    chk("rd_ready", 64'(req_rd_ready), 64'(erd));
    chk("wr_ready", 64'(req_wr_ready), 64'(ewr));
    if (erd != '0) begin
      w = oh_idx(erd);
      rd_q.push_back('{due: cyc + 1, bnk: p_rd_bnk[w], adr: p_rd_adr[w], bw: '0, din: '0});
      rsp_q.push_back('{due: cyc + 1 + RDD, tag: w});
    end
    if (ewr != '0) begin
      w = oh_idx(ewr);
      wr_q.push_back('{due: cyc + 1, bnk: p_wr_bnk[w], adr: p_wr_adr[w], bw: p_bw[w], din: p_din[w]});
    end
    $display("txn cyc=%0d rd_req=%b wr_req=%b rd_gnt=%b wr_gnt=%b", cyc, rd, wr, req_rd_ready, req_wr_ready);
  endtask

  // Expects rst to have just been released ahead of the next rising edge.
  task automatic check_sweep();
    req_read  = '1;
    req_write = '1;
    for (int k = 0; k < SWEEP; k++) begin
      @(negedge clk);
      chk("sweep_write", 64'(write), 64'd1);
      chk("sweep_bnk", 64'(wr_bnk), 64'(k / NV));
      chk("sweep_adr", 64'(wr_adr), 64'(k % NV));
      chk("sweep_bw", 64'(bw), 64'hFFFF_FFFF);
      chk("sweep_din", 64'(din), 64'd0);
      chk("sweep_read", 64'(read), 64'd0);
      chk("sweep_rd_ready", 64'(req_rd_ready), 64'd0);
      chk("sweep_wr_ready", 64'(req_wr_ready), 64'd0);
      chk("sweep_init_done", 64'(init_done), 64'd0);
      chk("sweep_rsp_vld", 64'(rsp_vld), 64'd0);
      $display("txn cyc=%0d sweep bnk=%0d row=%0d", cyc, wr_bnk, wr_adr);
    end
    req_read  = '0;
    req_write = '0;
    @(negedge clk);
    chk("init_done_after_sweep", 64'(init_done), 64'd1);
    chk("write_after_sweep", 64'(write), 64'd0);
  endtask

  typedef struct {
    logic [NR-1:0] rd_req;
    logic [NR-1:0] wr_req;
    logic [NR-1:0] exp_rd;
    logic [NR-1:0] exp_wr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0101, 4'b1010, 4'b0100, 4'b0010};
    tbl[7]  = '{4'b0001, 4'b1010, 4'b0001, 4'b1000};
    tbl[8]  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
    tbl[9]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0010};
    tbl[10] = '{4'b0011, 4'b1111, 4'b0010, 4'b0100};
    tbl[11] = '{4'b1001, 4'b0110, 4'b1000, 4'b0010};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

    rand_payload();
    req_read  = '1;
    req_write = '1;
    repeat (3) @(negedge clk);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rd_ready", 64'(req_rd_ready), 64'd0);
    chk("rst_wr_ready", 64'(req_wr_ready), 64'd0);
    #1 rst = 1'b0;
    check_sweep();
    mon_en = 1'b1;

    for (int v = 0; v < 13; v++) apply(tbl[v].rd_req, tbl[v].wr_req, tbl[v].exp_rd, tbl[v].exp_wr, 1'b1);

    // Same bank/row written by requester 1 and read by requester 3 in one cycle.
    p_wr_bnk[1] = 3'd3;
    p_wr_adr[1] = 10'd5;
    p_din[1]    = 32'hA5A5_A5A5;
    p_bw[1]     = 32'hFFFF_0000;
    p_rd_bnk[3] = 3'd3;
    p_rd_adr[3] = 10'd5;
    apply(4'b1000, 4'b0010, 4'b1000, 4'b0010, 1'b0);
    // Read pointer wrapped 3+1 -> 0, so requester 0 wins over 3.
    apply(4'b1001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    repeat (RDD + 2) apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Two reads in flight when reset hits: their responses must vanish.
    apply(4'b0011, 4'b0000, 4'b0010, 4'b0000, 1'b1);
    apply(4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    req_read = '0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("inflight_before_rst", 64'(rsp_q.size()), 64'd2);
    rsp_q.delete();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("rst_mid_read", 64'(read), 64'd0);
    end
    #1 rst = 1'b0;
    check_sweep();
    mon_en = 1'b1;

    // Pointer back at 0 after reset: requester 0 wins over 1.
    apply(4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    repeat (RDD + 2) apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("pending_expectations", 64'(rd_q.size() + wr_q.size() + rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/infra_align_bw_sched.md
Name: infra_align_bw_sched

Overview:
- Multi-requester scheduler in front of the align_bw_pseudo core's single write port and single read port.
- Arbitrates NUMREQ write requesters and NUMREQ read requesters, each side with independent round-robin.
- Tracks in-flight reads so that each read response is steered back to the requester that issued it.
- Optionally sweeps the whole memory to zero after reset before it admits any traffic.

Parameters:
NUMREQ, 4, number of requesters per port
BITREQ, 2, log2(NUMREQ)
WIDTH, 32, data/byte-write width
NUMVROW, 1024, rows per bank
BITVROW, 10, row address width
NUMVBNK, 8, banks
BITVBNK, 3, bank address width
RD_DELAY, 3, core read latency (read asserted to rd_dout valid), >=1
RSTINIT, 1, 1 = zero-fill sweep after reset, 0 = skip

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_write  in  NUMREQ  per-requester write valid
req_wr_bnk  in  NUMREQ*BITVBNK  write bank, requester i at slice i
req_wr_adr  in  NUMREQ*BITVROW  write row
req_bw  in  NUMREQ*WIDTH  bit-write enables
req_din  in  NUMREQ*WIDTH  write data
req_wr_ready  out  NUMREQ  write grant (one-hot or zero)
req_read  in  NUMREQ  per-requester read valid
req_rd_bnk  in  NUMREQ*BITVBNK  read bank
req_rd_adr  in  NUMREQ*BITVROW  read row
req_rd_ready  out  NUMREQ  read grant (one-hot or zero)
rsp_vld  out  NUMREQ  one-hot read response valid
rsp_dout  out  WIDTH  response data
rsp_serr  out  1  single-bit error flag of response
rsp_derr  out  1  double-bit error flag of response
write  out  1  core write
wr_bnk  out  BITVBNK  core write bank
wr_adr  out  BITVROW  core write row
bw  out  WIDTH  core bit-write enables
din  out  WIDTH  core write data
read  out  1  core read
rd_bnk  out  BITVBNK  core read bank
rd_adr  out  BITVROW  core read row
rd_dout  in  WIDTH  core read data
rd_serr  in  1  core single-bit error
rd_derr  in  1  core double-bit error
init_done  out  1  high once the scheduler is in RUN

Behaviour:
- FSM states: INIT, RUN.
- rst drives the FSM to INIT when RSTINIT=1, otherwise to RUN.
- Reset values: all core outputs 0, rsp_vld 0, init_done 0, both round-robin pointers 0, read-tag pipeline cleared.
- INIT sweep:
  - One write per cycle with bw all ones and din 0.
  - Row counter is inner, bank counter outer. Row wraps at NUMVROW-1 and then increments bank, so NUMVROW need not be a power of 2.
  - After the write to bank NUMVBNK-1, row NUMVROW-1, the FSM goes to RUN on the next cycle. Total NUMVBNK*NUMVROW write cycles.
  - During INIT, req_wr_ready and req_rd_ready are 0 and read is 0.
- RUN: init_done=1. A requester's ready is asserted combinationally from its valid. Handshake = valid && ready in the same cycle.
- Round-robin:
  - Search starts at the pointer index, ascending with wrap.
  - On a grant, the pointer moves to winner+1 mod NUMREQ; with no grant, the pointer holds.
  - Read and write arbiters are fully independent. Requesters are expected to hold valid and payload until granted.
- Issue: the granted payload is registered. Core write/read is asserted exactly 1 cycle after the handshake (accept at T, core command at T+1). A request can be accepted every cycle (full throughput).
- Response steering:
  - Read accepted at T carries tag = winner index through a RD_DELAY+1 stage valid/tag shift pipeline.
  - rsp_vld[tag] is asserted at T+1+RD_DELAY.
  - rsp_dout, rsp_serr and rsp_derr pass rd_dout, rd_serr and rd_derr through combinationally. When no rsp_vld bit is set they are don't-care.
- Simultaneous events:
  - A read and a write in the same cycle are both issued, including same bank/row; read-during-write forwarding is the core's responsibility.
  - No ordering is enforced between different requesters.
- Out-of-range bank/row in a request is not checked; it is passed to the core unchanged.
- Reset mid-operation: in-flight read tags are discarded (no rsp_vld for them), any INIT sweep restarts from bank 0/row 0, and pointers return to 0.

Decomposition:
- Package infra_align_bw_sched_pkg holds the FSM state enum (INIT, RUN) and the sweep-length constant NUMVBNK*NUMVROW.
- Sub-module infra_rr_arb (params NUMREQ, BITREQ): req vector in; one-hot grant, winner index and pointer register out. It is instantiated twice, once for reads and once for writes.

Test Plan:
- RSTINIT=1, NUMVBNK=2, NUMVROW=4: deassert rst -> 8 consecutive core writes covering (bnk,row) (0,0)..(1,3) with bw=all ones and din=0, then init_done=1 on cycle 9; no ready during the sweep.
- Read requesters 0,1,2,3 all valid continuously, pointer 0 -> grants 0,1,2,3,0 on successive cycles; core read asserted 1 cycle after each grant.
- RD_DELAY=3: requester 2 read accepted at T=10 -> read=1 at 11, rsp_vld=4'b0100 at 14 with rsp_dout equal to rd_dout of that cycle.
- Requester 1 writes bank 3 row 5 din=0xA5A5A5A5 bw=0xFFFF0000 while requester 3 reads bank 3 row 5 in the same cycle -> both core commands issued the next cycle; rsp_vld[3] returned after RD_DELAY.
- rst asserted while 2 reads are in flight -> no rsp_vld for those reads; the INIT sweep restarts at (0,0).
- Only requester 3 valid with the pointer at 0 -> requester 3 granted the same cycle and the pointer becomes 0 (3+1 wraps to 0).
